// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch/issue stage and the control decoder:
// opcode/function encodings, instruction field positions, fetch FSM states.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b111111;
  localparam logic [5:0] OP_HALT  = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000001;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  // state    | meaning
  // ST_IDLE  | quiet, memory loadable, waiting for start
  // ST_FETCH | reading mem[pc] into the instruction register
  // ST_ISSUE | presenting the fields (or detecting HALT)
  // ST_DONE  | program finished, memory loadable, restartable
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Load port, start, and the instruction handshake towards the decoder.
// master = the fetch/issue unit, slave = the side driving loads/ready.
interface instr_fetch_issue_if #(
  parameter int ADDR_W = 5
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              instr_ready;
  logic              instr_valid;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        fn_code;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [7:0]        issue_count;

  modport master (
    input  load_en, load_addr, load_data, start, instr_ready,
    output instr_valid, opcode, rs, rt, rd, shamt, fn_code,
           pc, busy, done, issue_count
  );

  modport slave (
    output load_en, load_addr, load_data, start, instr_ready,
    input  instr_valid, opcode, rs, rt, rd, shamt, fn_code,
           pc, busy, done, issue_count
  );
endinterface

// File: rtl/imem_sync.sv
// Instruction memory: one write port, registered read. The read register
// doubles as the instruction register, so it is reset while the array is not.
module imem_sync #(
  parameter int IMEM_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [IMEM_DEPTH];
  logic [31:0] r_rdata;

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, loaded only when the fetch FSM asks for it.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: steps pc through the instruction memory, splits each
// word into fields and hands them to the decoder with valid/ready.
// ADDR_W must equal clog2(IMEM_DEPTH).
module instr_fetch_issue
  import cpu_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_issue_if.master bus
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_issue_count;
  logic [31:0]       w_instr;
  logic              w_loadable;
  logic              w_we;
  logic              w_start;
  logic              w_fetch;
  logic              w_is_halt;
  logic              w_valid;
  logic              w_accept;
  logic              w_last;

  // Loads and start only count in the two resting states.
  assign w_loadable = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_we       = bus.load_en && w_loadable;
  assign w_start    = bus.start && w_loadable;
  assign w_fetch    = (r_state == ST_FETCH);
  assign w_is_halt  = (w_instr[OPC_MSB:OPC_LSB] == OP_HALT);
  assign w_valid    = (r_state == ST_ISSUE) && !w_is_halt;
  assign w_accept   = w_valid && bus.instr_ready;
  assign w_last     = (r_pc == ADDR_W'(IMEM_DEPTH - 1));

  imem_sync #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_imem (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(bus.load_addr),
    .i_wdata(bus.load_data),
    .i_re   (w_fetch),
    .i_raddr(r_pc),
    .o_rdata(w_instr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; HALT leaves pc on the HALT word, last word does not wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_state_nxt = ST_FETCH;
      ST_FETCH:         w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (w_is_halt)     w_state_nxt = ST_DONE;
        else if (w_accept) w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      end
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Program counter and saturating count of accepted instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_issue_count <= '0;
    end else if (w_start) begin
      r_pc          <= '0;
      r_issue_count <= '0;
    end else if (w_accept) begin
      if (!w_last)                 r_pc <= r_pc + ADDR_W'(1);
      if (r_issue_count != 8'hFF)  r_issue_count <= r_issue_count + 8'd1;
    end
  end

  assign bus.instr_valid = w_valid;
  assign bus.opcode      = w_instr[OPC_MSB:OPC_LSB];
  assign bus.rs          = w_instr[RS_MSB:RS_LSB];
  assign bus.rt          = w_instr[RT_MSB:RT_LSB];
  assign bus.rd          = w_instr[RD_MSB:RD_LSB];
  assign bus.shamt       = w_instr[SH_MSB:SH_LSB];
  assign bus.fn_code     = w_instr[FN_MSB:FN_LSB];
  assign bus.pc          = r_pc;
  assign bus.busy        = (r_state == ST_FETCH) || (r_state == ST_ISSUE);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.issue_count = r_issue_count;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: load/run, throughput, backpressure,
// end-of-memory stop, mid-issue reset and load gating.
module tb_instr_fetch_issue;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  instr_fetch_issue_if #(.ADDR_W(5)) bus ();

  instr_fetch_issue #(.IMEM_DEPTH(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [4:0] addr, input logic [31:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (bus.done) break;
      tick();
    end
    check(tag, {31'd0, bus.done}, 32'd1);
  endtask

  logic [5:0]  fn_exp [4];
  logic [31:0] prog   [5];

  initial begin
    n_checks = 0;
    n_err    = 0;
    fn_exp[0] = 6'b100000; fn_exp[1] = 6'b100010;
    fn_exp[2] = 6'b100100; fn_exp[3] = 6'b100101;
    prog[0] = 32'hFC221820; prog[1] = 32'hFC221822; prog[2] = 32'hFC221824;
    prog[3] = 32'hFC221825; prog[4] = 32'h00000000;

    rst_n           = 1'b0;
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_pc",    {27'd0, bus.pc}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);
    check("rst_count", {24'd0, bus.issue_count}, 32'd0);
    check("rst_opc",   {26'd0, bus.opcode}, 32'd0);
    check("rst_fn",    {26'd0, bus.fn_code}, 32'd0);

    // single instruction followed by HALT
    load_word(5'd0, 32'hFC221820);
    load_word(5'd1, 32'h00000000);
    bus.instr_ready = 1'b1;
    pulse_start();
    check("t1_fetch_busy",  {31'd0, bus.busy}, 32'd1);
    check("t1_fetch_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t1_opc",   {26'd0, bus.opcode}, 32'h3F);
    check("t1_rs",    {27'd0, bus.rs}, 32'd1);
    check("t1_rt",    {27'd0, bus.rt}, 32'd2);
    check("t1_rd",    {27'd0, bus.rd}, 32'd3);
    check("t1_shamt", {27'd0, bus.shamt}, 32'd0);
    check("t1_fn",    {26'd0, bus.fn_code}, 32'h20);
    tick();
    check("t1_drop",  {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("t1_halt_novalid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    check("t1_done",  {31'd0, bus.done}, 32'd1);
    check("t1_busy",  {31'd0, bus.busy}, 32'd0);
    check("t1_count", {24'd0, bus.issue_count}, 32'd1);
    check("t1_pc",    {27'd0, bus.pc}, 32'd1);

    // four R-type words then HALT, ready held high: one issue every 2 cycles
    for (int i = 0; i < 5; i++) load_word(5'(i), prog[i]);
    pulse_start();
    check("t2_done_drop", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_fetch_novalid", {31'd0, bus.instr_valid}, 32'd0);
      tick();
      check("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("t2_fn",    {26'd0, bus.fn_code}, {26'd0, fn_exp[i]});
      tick();
    end
    wait_done("t2_wait_done");
    check("t2_count", {24'd0, bus.issue_count}, 32'd4);
    check("t2_pc",    {27'd0, bus.pc}, 32'd4);

    // backpressure on word 0
    bus.instr_ready = 1'b0;
    pulse_start();
    tick();
    check("t3_valid0", {31'd0, bus.instr_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("t3_hold_fn",    {26'd0, bus.fn_code}, 32'h20);
      check("t3_hold_rd",    {27'd0, bus.rd}, 32'd3);
      check("t3_hold_pc",    {27'd0, bus.pc}, 32'd0);
      check("t3_hold_count", {24'd0, bus.issue_count}, 32'd0);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("t3_acc_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("t3_acc_count", {24'd0, bus.issue_count}, 32'd1);
    check("t3_acc_pc",    {27'd0, bus.pc}, 32'd1);
    tick();
    check("t3_w1_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t3_w1_fn",    {26'd0, bus.fn_code}, 32'h22);
    tick();
    check("t3_one_acc",  {24'd0, bus.issue_count}, 32'd1);

    // reset while presenting a valid instruction
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("t5_pc",    {27'd0, bus.pc}, 32'd0);
    check("t5_busy",  {31'd0, bus.busy}, 32'd0);
    check("t5_done",  {31'd0, bus.done}, 32'd0);
    check("t5_count", {24'd0, bus.issue_count}, 32'd0);
    check("t5_opc",   {26'd0, bus.opcode}, 32'd0);
    bus.instr_ready = 1'b1;
    pulse_start();
    tick();
    check("t5_re_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t5_re_fn",    {26'd0, bus.fn_code}, 32'h20);
    wait_done("t5_wait_done");
    check("t5_re_count", {24'd0, bus.issue_count}, 32'd4);

    // load while busy is dropped
    bus.instr_ready = 1'b0;
    pulse_start();
    tick();
    load_word(5'd0, 32'hFC221822);
    check("t6_busy_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t6_busy_fn",    {26'd0, bus.fn_code}, 32'h20);
    bus.instr_ready = 1'b1;
    wait_done("t6_wait_done1");
    pulse_start();
    tick();
    check("t6_mem_kept_fn", {26'd0, bus.fn_code}, 32'h20);
    wait_done("t6_wait_done2");
    // load and start in the same DONE cycle: the new word is fetched
    bus.load_en   = 1'b1;
    bus.load_addr = 5'd0;
    bus.load_data = 32'hFC221822;
    bus.start     = 1'b1;
    tick();
    bus.load_en   = 1'b0;
    bus.start     = 1'b0;
    check("t6_ls_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check("t6_ls_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("t6_ls_fn",    {26'd0, bus.fn_code}, 32'h22);
    wait_done("t6_wait_done3");
    check("t6_ls_count", {24'd0, bus.issue_count}, 32'd4);

    // whole memory without HALT: stops at the last word, no wrap
    for (int i = 0; i < 32; i++) load_word(5'(i), 32'hFC221800);
    pulse_start();
    wait_done("t4_wait_done");
    check("t4_count", {24'd0, bus.issue_count}, 32'd32);
    check("t4_pc",    {27'd0, bus.pc}, 32'd31);
    check("t4_busy",  {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    check("t4_nowrap_pc",   {27'd0, bus.pc}, 32'd31);
    check("t4_still_done",  {31'd0, bus.done}, 32'd1);
    check("t4_still_count", {24'd0, bus.issue_count}, 32'd32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Instruction-side producer for the control decoder (Control_sigs).
- Holds a small synchronous-read instruction memory, loaded through a write port while idle.
- Steps a PC through the memory, splits each 32-bit word into opcode/rs/rt/rd/shamt/fn_code, and presents the fields with a valid/ready handshake to the decode stage.
- Stops on a HALT word or at the end of memory.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit instruction words.
- ADDR_W, 5, PC/address width; must equal clog2(IMEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load_en  in  1  instruction-memory write strobe.
- load_addr  in  ADDR_W  write address.
- load_data  in  32  write data.
- start  in  1  begin execution from PC 0.
- instr_ready  in  1  downstream decoder accepts the current instruction.
- instr_valid  out  1  fields below are valid.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- fn_code  out  6  instr[5:0].
- pc  out  ADDR_W  address of the current or next fetch.
- busy  out  1  high in FETCH/ISSUE.
- done  out  1  high in DONE.
- issue_count  out  8  instructions accepted since start, saturating at 255.

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-issue:
  - state=IDLE, pc=0, instruction register=0, instr_valid=0, busy=0, done=0, issue_count=0.
  - Memory contents are not reset.
- Field outputs are always combinational slices of the instruction register; they are 0 after reset.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE:
  - Outputs quiet.
  - load_en writes mem[load_addr]<=load_data.
  - start=1 -> FETCH with pc=0 and issue_count=0.
- FETCH (1 cycle):
  - Instruction register <= mem[pc] (synchronous read); -> ISSUE.
  - busy=1, instr_valid=0.
- ISSUE, HALT word (opcode==OP_HALT, 6'b000000):
  - The word is not issued; instr_valid stays 0.
  - -> DONE next cycle; pc is unchanged and points at the HALT word.
- ISSUE, any other word:
  - instr_valid=1; fields are held stable until instr_ready=1.
  - On valid&&ready: issue_count increments (saturating).
  - If pc==IMEM_DEPTH-1, pc is held and the next state is DONE (no wrap).
  - Otherwise pc<=pc+1 and the next state is FETCH.
  - instr_valid drops the cycle after acceptance.
- Throughput: 1 instruction per 2 cycles when ready is held high. Latency from start to first instr_valid is 2 cycles.
- DONE:
  - done=1, busy=0, instr_valid=0.
  - load_en writes are permitted.
  - start=1 -> FETCH with pc=0 and issue_count=0; done drops the next cycle.
- load_en while busy is ignored: memory is unchanged and no error is raised.
- start while busy is ignored.
- load_en and start in the same IDLE/DONE cycle: the write completes, and FETCH in the next cycle reads the updated contents.
- instr_ready while instr_valid=0 has no effect.

Decomposition:
- Package cpu_isa_pkg holds:
  - OP_RTYPE=6'b111111 and OP_HALT=6'b000000.
  - FN_ADD=6'b100000, FN_SUB=6'b100010, FN_AND=6'b100100, FN_OR=6'b100101, FN_SLL=6'b000000, FN_SRL=6'b000001.
  - Field bit positions.
  - The state encoding type.
- The package is shared with Control_sigs.
- One sub-module, imem_sync: single write port, synchronous read, parameterised by IMEM_DEPTH/ADDR_W.

Test Plan:
- Load mem[0]=0xFC221820, mem[1]=0x00000000; pulse start, hold ready=1 -> two cycles later instr_valid=1 with opcode=111111, rs=1, rt=2, rd=3, fn_code=100000. After acceptance, done=1, issue_count=1, pc=1.
- Load ADD/SUB/AND/OR words 0xFC221820/22/24/25 then HALT; ready=1 -> four valid pulses, each 2 cycles apart, with fn_code in the sequence 100000, 100010, 100100, 100101. Ends with issue_count=4.
- Backpressure: ready=0 for 5 cycles on word 0 -> instr_valid and fields stay stable and pc stays 0. Raising ready gives exactly one acceptance.
- Fill all 32 words with the non-HALT word 0xFC221800 -> 32 issues, pc=31, done=1, no wrap to 0.
- Assert rst_n=0 for one cycle while in ISSUE with valid=1 -> next cycle valid=0, pc=0, state IDLE. Memory is retained, so a restart reissues the same program.
- load_en to addr 0 while busy -> ignored, original word issued. The same write in DONE followed by start -> the new word is issued.
